pc_call_stack: RTL and testbench
================================

PC_CALL_STACK -- requirements
Module: pc_call_stack

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, program-counter and return-address width.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address entries (>=1).
REQ-003 Parameter RESET_VECTOR, default 0, counter value after reset or clear.
REQ-004 Parameter HALT_ON_FAULT, default 1; 1 = stack error freezes the block in FAULT.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-007 clear  in  1  synchronous re-initialise: counter, stack, flags, state.
REQ-008 enable  in  1  increment counter by 1.
REQ-009 load  in  1  jump: counter <= target.
REQ-010 call  in  1  push counter_out, counter <= target.
REQ-011 ret  in  1  pop top entry into counter.
REQ-012 halt  in  1  enter HALTED.
REQ-013 target  in  ADDR_WIDTH  jump/call destination.
REQ-014 counter_out  out  ADDR_WIDTH  current program counter.
REQ-015 level  out  $clog2(STACK_DEPTH+1)  occupied entries.
REQ-016 full, empty  out  1 each  level==STACK_DEPTH, level==0.
REQ-017 overflow, underflow  out  1 each  sticky error flags.
REQ-018 halted, faulted  out  1 each  state==HALTED, state==FAULT.

Function
REQ-019 States RUN, HALTED, FAULT; only RUN executes commands.
REQ-020 Per-cycle command priority in RUN: halt > call > ret > load > enable; lower commands ignored that cycle.
REQ-021 All updates register on the clock edge: counter_out and level reflect a command the cycle after it is sampled (latency 1).
REQ-022 enable: counter_out+1, wrapping 2^ADDR_WIDTH-1 -> 0, no flag.
REQ-023 load: counter_out <= target; stack untouched.
REQ-024 call not full: stack[level] <= counter_out, level+1, counter_out <= target.
REQ-025 call when full: no push, counter held, overflow set; HALT_ON_FAULT=1 -> FAULT.
REQ-026 ret not empty: counter_out <= stack[level-1], level-1.
REQ-027 ret when empty: counter held, underflow set; HALT_ON_FAULT=1 -> FAULT.
REQ-028 HALT_ON_FAULT=0: errors set flags only, state stays RUN.
REQ-029 halt in RUN -> HALTED, counter held; HALTED and FAULT leave only via clear or reset.
REQ-030 clear (any state, overrides all commands): counter RESET_VECTOR, level 0, flags 0, state RUN.
REQ-031 overflow/underflow remain set until clear or reset.

Reset
REQ-032 reset low asynchronously forces counter_out=RESET_VECTOR, level=0, empty=1, full=0, overflow=underflow=0, state RUN.
REQ-033 reset mid-call/ret discards the operation; stack contents need not be cleared, level=0 suffices.
REQ-034 First command takes effect on the first rising edge after reset deasserts.

Structure
REQ-035 pc_state_t enum (RUN, HALTED, FAULT) and default PC_STACK_DEPTH constant live in arch_defs_pkg.
REQ-036 Storage in sub-module pc_lifo (push/pop/level/full/empty), pc_call_stack owns counter and state machine.
REQ-037 No combinational path from command inputs to any output.

Verification (ADDR_WIDTH=8, STACK_DEPTH=4, HALT_ON_FAULT=1)
REQ-038 Reset, enable 5 cycles -> counter_out 0x05, level 0, empty 1.
REQ-039 counter 0x10, call target 0x40 -> 0x40, level 1; enable 2 cycles, ret -> 0x10, level 0.
REQ-040 Five nested calls from 0x00 (targets 0x20,0x30,0x40,0x50,0x60) -> after 4th full=1, counter 0x50; 5th sets overflow, faulted=1, counter 0x50; further enable ignored.
REQ-041 ret when empty -> underflow=1, faulted=1, counter unchanged; clear -> counter 0x00, flags 0, RUN.
REQ-042 load 0xFF then enable -> 0x00; halt together with call -> halted=1, level unchanged, counter 0x00.
REQ-043 reset low for 3 ns mid-cycle after two calls -> counter 0x00, level 0 immediately, without clock edge.

Source files
------------

// File: rtl/pc_call_stack_pkg.sv
// Shared definitions for the program-counter call stack: state encoding,
// default stack depth and the level-width helper.
package arch_defs_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } pc_state_t;

  localparam int PC_STACK_DEPTH = 4;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Command/status bundle between a sequencer (master) and pc_call_stack (slave).
interface pc_call_stack_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = arch_defs_pkg::PC_STACK_DEPTH
);
  import arch_defs_pkg::*;

  localparam int LW = level_width(STACK_DEPTH);

  // Commands are level-sampled on every rising edge with no backpressure;
  // status outputs are all registered and valid every cycle.
  logic                  clear;
  logic                  enable;
  logic                  load;
  logic                  call;
  logic                  ret;
  logic                  halt;
  logic [ADDR_WIDTH-1:0] target;

  logic [ADDR_WIDTH-1:0] counter_out;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;
  logic                  halted;
  logic                  faulted;
  pc_state_t             state;

  modport master (
    output clear, enable, load, call, ret, halt, target,
    input  counter_out, level, full, empty, overflow, underflow,
           halted, faulted, state
  );

  modport slave (
    input  clear, enable, load, call, ret, halt, target,
    output counter_out, level, full, empty, overflow, underflow,
           halted, faulted, state
  );

endinterface

// File: rtl/pc_call_stack_lifo.sv
// Return-address LIFO: registered level, uninitialised storage, top-of-stack
// read straight from the array.
module pc_lifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_top;

  assign w_top = r_level - LW'(1);
  assign dout  = r_mem[w_top[IW-1:0]];
  assign level = r_level;
  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == '0);

  // Contents are never reset; only entries below r_level are meaningful.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_level[IW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_level <= '0;
    else if (clear)  r_level <= '0;
    else if (push)   r_level <= r_level + LW'(1);
    else if (pop)    r_level <= r_level - LW'(1);
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with call/return stack and RUN/HALTED/FAULT state machine.
module pc_call_stack
  import arch_defs_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    STACK_DEPTH   = PC_STACK_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter bit                    HALT_ON_FAULT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  pc_call_stack_if.slave  bus
);

  localparam int LW = level_width(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] r_counter;
  pc_state_t             r_state;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_run;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_top;
  logic [LW-1:0]         w_level;
  logic                  w_full;
  logic                  w_empty;

  // Stack moves only when the command actually wins priority this cycle.
  assign w_run  = (r_state == RUN) && !bus.clear && !bus.halt;
  assign w_push = w_run && bus.call && !w_full;
  assign w_pop  = w_run && !bus.call && bus.ret && !w_empty;

  pc_lifo #(
    .W     (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH),
    .LW    (LW)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_counter),
    .dout  (w_top),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_counter   <= RESET_VECTOR;
      r_state     <= RUN;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clear) begin
      r_counter   <= RESET_VECTOR;
      r_state     <= RUN;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (r_state == RUN) begin
      if (bus.halt) begin
        r_state <= HALTED;
      end else if (bus.call) begin
        if (w_full) begin
          r_overflow <= 1'b1;
          if (HALT_ON_FAULT) r_state <= FAULT;
        end else begin
          r_counter <= bus.target;
        end
      end else if (bus.ret) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
          if (HALT_ON_FAULT) r_state <= FAULT;
        end else begin
          r_counter <= w_top;
        end
      end else if (bus.load) begin
        r_counter <= bus.target;
      end else if (bus.enable) begin
        r_counter <= r_counter + ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.counter_out = r_counter;
  assign bus.level       = w_level;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.halted      = (r_state == HALTED);
  assign bus.faulted     = (r_state == FAULT);
  assign bus.state       = r_state;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack: the driver queues hand-computed status
// snapshots, a monitor compares them against the DUT on the falling edge.
module tb_pc_call_stack;

  localparam int W = 17;

  logic clk;
  logic reset;

  pc_call_stack_if #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) bus ();

  pc_call_stack #(
    .ADDR_WIDTH    (8),
    .STACK_DEPTH   (4),
    .RESET_VECTOR  (8'h00),
    .HALT_ON_FAULT (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  event         chk_ev;

  function automatic logic [W-1:0] snap();
    return {bus.counter_out, bus.level, bus.full, bus.empty,
            bus.overflow, bus.underflow, bus.halted, bus.faulted};
  endfunction

  task automatic expect_st(input string n, input logic [7:0] cnt,
                           input logic [2:0] lvl, input logic ovf,
                           input logic unf, input logic hlt, input logic flt);
    logic full_e;
    logic empty_e;
    full_e  = (lvl == 3'd4);
    empty_e = (lvl == 3'd0);
    exp_q.push_back({cnt, lvl, full_e, empty_e, ovf, unf, hlt, flt});
    name_q.push_back(n);
  endtask

  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        n;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = snap();
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL %s: got cnt=%02h lvl/f/e/ovf/unf/h/flt=%03b_%06b expected cnt=%02h %03b_%06b",
                   n, a[16:9], a[8:6], a[5:0], e[16:9], e[8:6], e[5:0]);
        end
      end
    end
  end

  // driver
  task automatic do_cmd(input logic h, input logic c, input logic r,
                        input logic l, input logic en, input logic clr,
                        input logic [7:0] t);
    @(negedge clk);
    bus.halt   = h;
    bus.call   = c;
    bus.ret    = r;
    bus.load   = l;
    bus.enable = en;
    bus.clear  = clr;
    bus.target = t;
    @(posedge clk);
    #1;
    bus.halt   = 1'b0;
    bus.call   = 1'b0;
    bus.ret    = 1'b0;
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
  endtask

  //                          h    c    r    l    en   clr
  task automatic enable1();                do_cmd(0, 0, 0, 0, 1, 0, 8'h00); endtask
  task automatic load1(input logic [7:0] t); do_cmd(0, 0, 0, 1, 0, 0, t);   endtask
  task automatic call1(input logic [7:0] t); do_cmd(0, 1, 0, 0, 0, 0, t);   endtask
  task automatic ret1();                   do_cmd(0, 0, 1, 0, 0, 0, 8'h00); endtask
  task automatic clear1();                 do_cmd(0, 0, 0, 0, 0, 1, 8'h00); endtask

  initial begin
    bus.halt   = 1'b0;
    bus.call   = 1'b0;
    bus.ret    = 1'b0;
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.target = 8'h00;
    reset      = 1'b1;
    #1 reset   = 1'b0;
    #2;
    expect_st("reset", 8'h00, 3'd0, 0, 0, 0, 0);
    ->chk_ev;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // count up from reset
    for (int i = 1; i <= 5; i++) begin
      enable1();
      expect_st("enable", 8'(i), 3'd0, 0, 0, 0, 0);
    end

    // single call / return
    load1(8'h10);  expect_st("load_10",   8'h10, 3'd0, 0, 0, 0, 0);
    call1(8'h40);  expect_st("call_40",   8'h40, 3'd1, 0, 0, 0, 0);
    enable1();     expect_st("sub_en1",   8'h41, 3'd1, 0, 0, 0, 0);
    enable1();     expect_st("sub_en2",   8'h42, 3'd1, 0, 0, 0, 0);
    ret1();        expect_st("ret_10",    8'h10, 3'd0, 0, 0, 0, 0);

    // nested calls to overflow
    clear1();      expect_st("clear_a",   8'h00, 3'd0, 0, 0, 0, 0);
    call1(8'h20);  expect_st("nest1",     8'h20, 3'd1, 0, 0, 0, 0);
    call1(8'h30);  expect_st("nest2",     8'h30, 3'd2, 0, 0, 0, 0);
    call1(8'h40);  expect_st("nest3",     8'h40, 3'd3, 0, 0, 0, 0);
    call1(8'h50);  expect_st("nest4_full",8'h50, 3'd4, 0, 0, 0, 0);
    call1(8'h60);  expect_st("overflow",  8'h50, 3'd4, 1, 0, 0, 1);
    enable1();     expect_st("fault_en",  8'h50, 3'd4, 1, 0, 0, 1);
    ret1();        expect_st("fault_ret", 8'h50, 3'd4, 1, 0, 0, 1);

    // underflow
    clear1();      expect_st("clear_b",   8'h00, 3'd0, 0, 0, 0, 0);
    ret1();        expect_st("underflow", 8'h00, 3'd0, 0, 1, 0, 1);
    clear1();      expect_st("clear_c",   8'h00, 3'd0, 0, 0, 0, 0);

    // wrap, halt priority
    load1(8'hFF);  expect_st("load_ff",   8'hFF, 3'd0, 0, 0, 0, 0);
    enable1();     expect_st("wrap",      8'h00, 3'd0, 0, 0, 0, 0);
    do_cmd(1, 1, 0, 0, 0, 0, 8'h33);
                   expect_st("halt_call", 8'h00, 3'd0, 0, 0, 1, 0);
    enable1();     expect_st("halted_en", 8'h00, 3'd0, 0, 0, 1, 0);
    clear1();      expect_st("clear_d",   8'h00, 3'd0, 0, 0, 0, 0);

    // priority among call / ret / load / enable
    do_cmd(0, 1, 1, 1, 1, 0, 8'h70);
                   expect_st("call_wins", 8'h70, 3'd1, 0, 0, 0, 0);
    do_cmd(0, 0, 1, 1, 1, 0, 8'h99);
                   expect_st("ret_wins",  8'h00, 3'd0, 0, 0, 0, 0);
    do_cmd(0, 0, 0, 1, 1, 0, 8'hA5);
                   expect_st("load_wins", 8'hA5, 3'd0, 0, 0, 0, 0);
    do_cmd(0, 1, 0, 0, 0, 1, 8'h44);
                   expect_st("clear_wins",8'h00, 3'd0, 0, 0, 0, 0);

    // asynchronous reset mid-cycle
    call1(8'h20);  expect_st("pre_rst1",  8'h20, 3'd1, 0, 0, 0, 0);
    call1(8'h30);  expect_st("pre_rst2",  8'h30, 3'd2, 0, 0, 0, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    expect_st("async_rst", 8'h00, 3'd0, 0, 0, 0, 0);
    ->chk_ev;
    #2 reset = 1'b1;
    enable1();     expect_st("post_rst",  8'h01, 3'd0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
